// File: rtl/ucsbece154b_burst_reader.sv
// Burst reader: pops one request from the queue, waits a fixed read latency, then
// streams one block critical-word-first over a valid/ready response port.
module ucsbece154b_burst_reader #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int BLOCK_WORDS  = 4,
    parameter int READ_LATENCY = 10
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           req_valid_i,
    input  logic [ADDR_WIDTH-1:0]          req_addr_i,
    output logic                           req_pop_o,
    output logic [ADDR_WIDTH-1:0]          mem_addr_o,
    input  logic [DATA_WIDTH-1:0]          mem_rdata_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [DATA_WIDTH-1:0]          rsp_data_o,
    output logic [$clog2(BLOCK_WORDS)-1:0] rsp_word_o,
    output logic                           rsp_last_o,
    output logic                           busy_o,
    output logic [15:0]                    bursts_o
);

    localparam int IW = $clog2(BLOCK_WORDS);
    localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int BW = ADDR_WIDTH - IW - 2;
    localparam logic [LW-1:0] LAT_LOAD  = LW'(READ_LATENCY - 1);
    localparam logic [IW-1:0] BEAT_LAST = {IW{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t          r_state;
    logic [LW-1:0]   r_lat_cnt;
    logic [BW-1:0]   r_base;
    logic [IW-1:0]   r_word;
    logic [IW-1:0]   r_beats;
    logic [15:0]     r_bursts;

    state_t          w_state_nxt;
    logic [LW-1:0]   w_lat_nxt;
    logic [BW-1:0]   w_base_nxt;
    logic [IW-1:0]   w_word_nxt;
    logic [IW-1:0]   w_beats_nxt;
    logic [15:0]     w_bursts_nxt;

    // Byte-offset bits of the request address carry no meaning for word reads.
    logic w_unused;
    assign w_unused = ^req_addr_i[1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_lat_cnt <= '0;
            r_base    <= '0;
            r_word    <= '0;
            r_beats   <= '0;
            r_bursts  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lat_cnt <= w_lat_nxt;
            r_base    <= w_base_nxt;
            r_word    <= w_word_nxt;
            r_beats   <= w_beats_nxt;
            r_bursts  <= w_bursts_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_lat_nxt    = r_lat_cnt;
        w_base_nxt   = r_base;
        w_word_nxt   = r_word;
        w_beats_nxt  = r_beats;
        w_bursts_nxt = r_bursts;
        req_pop_o    = 1'b0;
        rsp_valid_o  = 1'b0;
        rsp_last_o   = 1'b0;
        rsp_data_o   = '0;

        case (r_state)
            IDLE: begin
                if (req_valid_i) begin
                    req_pop_o   = 1'b1;
                    w_base_nxt  = req_addr_i[ADDR_WIDTH-1:IW+2];
                    w_word_nxt  = req_addr_i[IW+1:2];
                    w_beats_nxt = '0;
                    w_lat_nxt   = LAT_LOAD;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_state_nxt = BURST;
                end else begin
                    w_lat_nxt = r_lat_cnt - LW'(1);
                end
            end
            BURST: begin
                rsp_valid_o = 1'b1;
                rsp_data_o  = mem_rdata_i;
                rsp_last_o  = (r_beats == BEAT_LAST);
                if (rsp_ready_i) begin
                    // Index wraps naturally within the block (power-of-two width).
                    w_word_nxt  = r_word + IW'(1);
                    w_beats_nxt = r_beats + IW'(1);
                    if (r_beats == BEAT_LAST) begin
                        w_bursts_nxt = r_bursts + 16'd1;
                        w_state_nxt  = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign mem_addr_o = {r_base, r_word, 2'b00};
    assign rsp_word_o = r_word;
    assign busy_o     = (r_state != IDLE);
    assign bursts_o   = r_bursts;

endmodule

// File: doc/ucsbece154b_burst_reader.md
UCSBECE154B_BURST_READER -- requirements
Module: ucsbece154b_burst_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 SHALL have parameter BLOCK_WORDS, default 4, words per burst; power of two, at least 2.
REQ-004 SHALL have parameter READ_LATENCY, default 10, cycles between request accept and first beat; at least 1.
REQ-005 SHALL have port clk_i  input  1  clock, rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port req_valid_i  input  1  request queue non-empty (driven by the request fifo valid_o).
REQ-008 SHALL have port req_addr_i  input  ADDR_WIDTH  byte address at the queue head (driven by the request fifo data_o).
REQ-009 SHALL have port req_pop_o  output  1  pop strobe to the request fifo pop_i.
REQ-010 SHALL have port mem_addr_o  output  ADDR_WIDTH  byte address to the combinational word-read memory.
REQ-011 SHALL have port mem_rdata_i  input  DATA_WIDTH  word read at mem_addr_o in the same cycle.
REQ-012 SHALL have port rsp_valid_o  output  1  response beat valid.
REQ-013 SHALL have port rsp_ready_i  input  1  consumer accepts the beat.
REQ-014 SHALL have port rsp_data_o  output  DATA_WIDTH  beat data.
REQ-015 SHALL have port rsp_word_o  output  $clog2(BLOCK_WORDS)  word index of the beat within its block.
REQ-016 SHALL have port rsp_last_o  output  1  final beat of the burst.
REQ-017 SHALL have port busy_o  output  1  high when the state is not IDLE.
REQ-018 SHALL have port bursts_o  output  16  count of completed bursts.

Function
REQ-019 SHALL implement three states: IDLE, WAIT and BURST.
REQ-020 SHALL, in IDLE with req_valid_i=1, drive req_pop_o=1 combinationally in that cycle, latch req_addr_i, load the latency counter with READ_LATENCY-1 and move to WAIT.
REQ-021 SHALL keep req_pop_o=0 in WAIT and BURST, and in IDLE whenever req_valid_i=0.
REQ-022 SHALL, in WAIT, move to BURST when the latency counter is 0 and otherwise decrement it, so that WAIT lasts exactly READ_LATENCY cycles.
REQ-023 SHALL deliver the first beat of an accepted request (pop in cycle T) at cycle T+READ_LATENCY+1.
REQ-024 SHALL deliver words critical-word-first: the start index is req_addr_i[log2(BLOCK_WORDS)+1:2], the index increments modulo BLOCK_WORDS, and the burst wraps within the block.
REQ-025 SHALL form mem_addr_o as {block base from the latched address, rsp_word_o, 2'b00}; the byte-offset bits of req_addr_i SHALL be ignored.
REQ-026 SHALL, in BURST, drive rsp_valid_o=1 and rsp_data_o=mem_rdata_i.
REQ-027 SHALL advance the index only on rsp_valid_o && rsp_ready_i; with rsp_ready_i=0 all outputs SHALL hold stable.
REQ-028 SHALL assert rsp_last_o on the BLOCK_WORDS-th beat; on that handshake it SHALL return to IDLE and increment bursts_o.
REQ-029 SHALL not pop in the cycle of the last handshake; the earliest next pop is the following cycle (IDLE).
REQ-030 SHALL let bursts_o wrap from 0xFFFF to 0.
REQ-031 SHALL drive rsp_valid_o=0, rsp_last_o=0 and rsp_data_o=0 outside BURST; mem_addr_o is don't-care outside BURST.

Reset
REQ-032 SHALL, on rst_i at any time including mid-WAIT or mid-BURST, immediately enter IDLE and clear the counters, index, latched address and bursts_o; the outputs SHALL be req_pop_o=0 (while req_valid_i=0), rsp_valid_o=0, rsp_last_o=0, busy_o=0 and bursts_o=0.
REQ-033 SHALL NOT re-deliver a burst that was aborted by reset; its request is already popped and is lost.

Verification (BLOCK_WORDS=4, READ_LATENCY=3, memory word = byte address)
REQ-034 SHALL test: req 0x00001008 popped at T, rsp_ready_i=1 -> beats at T+4..T+7 with data 0x1008, 0x100C, 0x1000, 0x1004, rsp_word_o 2,3,0,1, rsp_last_o on T+7, bursts_o=1 at T+8.
REQ-035 SHALL test: req 0x00002003 -> first beat addr 0x2000 (byte offset ignored), words 0,1,2,3.
REQ-036 SHALL test: rsp_ready_i low for 5 cycles at the second beat -> beat 2 held stable with no skipped or duplicated words, burst completes 5 cycles later.
REQ-037 SHALL test: two queued requests -> second pop occurs exactly 1 cycle after the first burst's last handshake, and its first beat arrives 4 cycles after that pop.
REQ-038 SHALL test: rst_i pulsed during WAIT and during BURST -> busy_o=0 and rsp_valid_o=0 immediately; no beats until a new request; bursts_o=0.
REQ-039 SHALL test: req_valid_i=0 for 20 cycles -> req_pop_o stays 0 and busy_o stays 0.
